// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: nibble, ROM address, instruction phases and
// the I/O-RAM group opcodes, plus constants used by the CPU bus controller.
package mcs4;

    typedef logic [3:0]  char_t;
    typedef logic [11:0] rom_addr_t;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef enum logic [3:0] {
        WRM = 4'h0,
        WMP = 4'h1,
        WRR = 4'h2,
        WPM = 4'h3,
        WR0 = 4'h4,
        WR1 = 4'h5,
        WR2 = 4'h6,
        WR3 = 4'h7,
        SBM = 4'h8,
        RDM = 4'h9,
        RDR = 4'hA,
        ADM = 4'hB,
        RD0 = 4'hC,
        RD1 = 4'hD,
        RD2 = 4'hE,
        RD3 = 4'hF
    } ioram_opa_t;

    localparam char_t     Opr_io      = 4'hE;
    localparam char_t     Opr_fin_src = 4'h2;
    localparam rom_addr_t Reset_pc    = 12'h000;

endpackage

// File: rtl/i4004_pc.sv
// 12-bit program counter: reset value, jump load and wrapping increment,
// advancing only on the enabled (end of X3) clock.
module i4004_pc
    import mcs4::*;
#(
    parameter rom_addr_t RESET_PC = Reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [11:0] load_addr,
    output logic [11:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= load ? load_addr : pc + 12'd1;
        end
    end

endmodule

// File: rtl/i4004_bus_ctrl.sv
// CPU-side MCS-4 bus controller: 8-phase instruction cycle, PC drive in A1-A3,
// OPR/OPA capture in M1/M2, cm_rom generation and X2/X3 data exchange with the core.
module i4004_bus_ctrl
    import mcs4::*;
#(
    parameter rom_addr_t RESET_PC = Reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sync,
    output logic        cl_rom,
    output logic        cm_rom,
    input  logic [3:0]  dbus_in,
    output logic [3:0]  dbus_out,
    output logic        instr_valid,
    output logic [3:0]  instr_opr,
    output logic [3:0]  instr_opa,
    output logic [11:0] instr_pc,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr,
    input  logic        x_drive,
    input  logic [3:0]  x2_nibble,
    input  logic [3:0]  x3_nibble,
    output logic [3:0]  x2_in,
    output logic        x2_in_valid
);

    instr_cyc_t icyc;
    logic       in_rst;
    char_t      opr_q;
    char_t      opa_q;
    rom_addr_t  pc;
    logic       pc_en;

    // The X3 phase held during reset is a parking state, not a real cycle end:
    // in_rst keeps it from advancing the PC or driving the bus.
    assign pc_en = (icyc == X3) && !in_rst;

    i4004_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .en       (pc_en),
        .load     (pc_load),
        .load_addr(pc_load_addr),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            icyc     <= X3;
            in_rst   <= 1'b1;
            cl_rom   <= 1'b1;
            opr_q    <= '0;
            opa_q    <= '0;
            x2_in    <= '0;
            instr_pc <= RESET_PC;
        end else begin
            icyc   <= instr_cyc_t'(icyc + 3'd1);
            in_rst <= 1'b0;
            if (pc_en) begin
                cl_rom   <= 1'b0;
                instr_pc <= pc;
            end
            case (icyc)
                M1:      opr_q <= dbus_in;
                M2:      opa_q <= dbus_in;
                X2:      x2_in <= dbus_in;
                default: ;
            endcase
        end
    end

    assign sync        = (icyc == X3);
    assign instr_valid = (icyc == X1);
    assign x2_in_valid = (icyc == X3) && !in_rst;
    assign instr_opr   = opr_q;
    assign instr_opa   = opa_q;

    always_comb begin
        dbus_out = '0;
        if (!in_rst) begin
            case (icyc)
                A1:      dbus_out = pc[3:0];
                A2:      dbus_out = pc[7:4];
                A3:      dbus_out = pc[11:8];
                X2:      dbus_out = x_drive ? x2_nibble : 4'h0;
                X3:      dbus_out = x_drive ? x3_nibble : 4'h0;
                default: dbus_out = '0;
            endcase
        end
    end

    always_comb begin
        cm_rom = 1'b0;
        if (!in_rst) begin
            case (icyc)
                M2:      cm_rom = (opr_q == Opr_io);
                X2:      cm_rom = (opr_q == Opr_fin_src) && opa_q[0];
                default: cm_rom = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i4004_bus_ctrl.sv
// Bench for i4004_bus_ctrl: a vector table of instruction cycles fed from a
// behavioural ROM/IO model, with fetched instructions scored through a queue.
module tb_i4004_bus_ctrl;
    import mcs4::*;

    localparam logic [11:0] TB_RESET_PC = 12'h000;

    logic        clk;
    logic        rst;
    logic        sync;
    logic        cl_rom;
    logic        cm_rom;
    logic [3:0]  dbus_in;
    logic [3:0]  dbus_out;
    logic        instr_valid;
    logic [3:0]  instr_opr;
    logic [3:0]  instr_opa;
    logic [11:0] instr_pc;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic        x_drive;
    logic [3:0]  x2_nibble;
    logic [3:0]  x3_nibble;
    logic [3:0]  x2_in;
    logic        x2_in_valid;

    i4004_bus_ctrl #(
        .RESET_PC(TB_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync        (sync),
        .cl_rom      (cl_rom),
        .cm_rom      (cm_rom),
        .dbus_in     (dbus_in),
        .dbus_out    (dbus_out),
        .instr_valid (instr_valid),
        .instr_opr   (instr_opr),
        .instr_opa   (instr_opa),
        .instr_pc    (instr_pc),
        .pc_load     (pc_load),
        .pc_load_addr(pc_load_addr),
        .x_drive     (x_drive),
        .x2_nibble   (x2_nibble),
        .x3_nibble   (x3_nibble),
        .x2_in       (x2_in),
        .x2_in_valid (x2_in_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  word;
        logic        xd;
        logic [3:0]  x2n;
        logic [3:0]  x3n;
        logic        ld;
        logic [2:0]  ld_ph;
        logic [11:0] ld_addr;
        logic [3:0]  rd;
        logic        cm_m2;
        logic        cm_x2;
    } vec_t;

    typedef struct {
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic [11:0] ipc;
    } exp_t;

    vec_t        vecs[11];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [11:0] mpc;
    logic [11:0] prev_pc;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s@c%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Walks one instruction cycle starting at the negedge inside A1.
    // A stop_ph below 8 asserts rst during that phase and returns after the reset edge.
    task automatic run_cycle(input vec_t v, input logic first, input int stop_ph);
        exp_t        e;
        exp_t        got;
        logic [3:0]  bus_exp;
        logic        cm_exp;
        logic [3:0]  x2_exp;
        x2_exp = v.rd | (v.xd ? v.x2n : 4'h0);
        for (int p = 0; p < 8; p++) begin
            pc_load      = v.ld && (v.ld_ph == 3'(p));
            pc_load_addr = v.ld_addr;
            x_drive      = v.xd;
            x2_nibble    = v.x2n;
            x3_nibble    = v.x3n;
            case (p)
                0: begin
                    dbus_in = 4'h0;
                    e.opr = v.word[7:4];
                    e.opa = v.word[3:0];
                    e.ipc = prev_pc;
                    sb.push_back(e);
                end
                3:       dbus_in = v.word[7:4];
                4:       dbus_in = v.word[3:0];
                6:       dbus_in = x2_exp;
                default: dbus_in = 4'h0;
            endcase
            #1;
            case (p)
                0:       bus_exp = mpc[3:0];
                1:       bus_exp = mpc[7:4];
                2:       bus_exp = mpc[11:8];
                6:       bus_exp = v.xd ? v.x2n : 4'h0;
                7:       bus_exp = v.xd ? v.x3n : 4'h0;
                default: bus_exp = 4'h0;
            endcase
            cm_exp = (p == 4) ? v.cm_m2 : (p == 6) ? v.cm_x2 : 1'b0;
            chk($sformatf("dbus_out.p%0d", p), 12'(dbus_out), 12'(bus_exp));
            chk($sformatf("cm_rom.p%0d", p), 12'(cm_rom), 12'(cm_exp));
            chk($sformatf("sync.p%0d", p), 12'(sync), 12'(p == 7));
            chk($sformatf("instr_valid.p%0d", p), 12'(instr_valid), 12'(p == 5));
            chk($sformatf("x2_in_valid.p%0d", p), 12'(x2_in_valid), 12'(p == 7));
            chk($sformatf("cl_rom.p%0d", p), 12'(cl_rom), 12'(first));
            if (p == 5) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard@c%0d: got empty queue, expected an entry", cyc);
                end else begin
                    got = sb.pop_front();
                    chk("instr_opr", 12'(instr_opr), 12'(got.opr));
                    chk("instr_opa", 12'(instr_opa), 12'(got.opa));
                    chk("instr_pc", instr_pc, got.ipc);
                end
            end
            if (p == 7) chk("x2_in", 12'(x2_in), 12'(x2_exp));
            if (p == stop_ph) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        prev_pc = mpc;
        mpc = (v.ld && v.ld_ph == 3'd7) ? v.ld_addr : mpc + 12'd1;
        cyc++;
    endtask

    task automatic check_reset_state();
        #1;
        chk("rst.sync", 12'(sync), 12'h1);
        chk("rst.cl_rom", 12'(cl_rom), 12'h1);
        chk("rst.dbus_out", 12'(dbus_out), 12'h0);
        chk("rst.cm_rom", 12'(cm_rom), 12'h0);
        chk("rst.instr_valid", 12'(instr_valid), 12'h0);
        chk("rst.x2_in_valid", 12'(x2_in_valid), 12'h0);
        chk("rst.instr_pc", instr_pc, TB_RESET_PC);
        chk("rst.x2_in", 12'(x2_in), 12'h0);
        chk("rst.instr_opr", 12'(instr_opr), 12'h0);
        chk("rst.instr_opa", 12'(instr_opa), 12'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        //           word   xd    x2n   x3n   ld    ld_ph  ld_addr  rd    cm_m2 cm_x2
        vecs[0]  = '{8'hD5, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 12'h000, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 3'd7, 12'hFFF, 4'h0, 1'b0, 1'b0};
        vecs[2]  = '{8'hE2, 1'b1, 4'hA, 4'h5, 1'b0, 3'd7, 12'h000, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{8'h21, 1'b1, 4'h3, 4'h0, 1'b0, 3'd7, 12'h000, 4'h0, 1'b0, 1'b1};
        vecs[4]  = '{8'hEA, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 12'h000, 4'h6, 1'b1, 1'b0};
        vecs[5]  = '{8'h23, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 12'h000, 4'h0, 1'b0, 1'b1};
        vecs[6]  = '{8'h20, 1'b0, 4'h0, 4'h0, 1'b1, 3'd5, 12'h123, 4'h0, 1'b0, 1'b0};
        vecs[7]  = '{8'hE0, 1'b1, 4'hF, 4'hC, 1'b0, 3'd7, 12'h000, 4'h0, 1'b1, 1'b0};
        vecs[8]  = '{8'h2E, 1'b0, 4'h0, 4'h0, 1'b1, 3'd7, 12'h123, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{8'h3F, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 12'h000, 4'h9, 1'b0, 1'b0};
        vecs[10] = '{8'h40, 1'b0, 4'h0, 4'h0, 1'b0, 3'd7, 12'h000, 4'h0, 1'b0, 1'b0};

        rst          = 1'b1;
        dbus_in      = 4'h0;
        pc_load      = 1'b0;
        pc_load_addr = 12'h000;
        x_drive      = 1'b1;
        x2_nibble    = 4'h0;
        x3_nibble    = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst     = 1'b0;
        x_drive = 1'b0;
        mpc     = TB_RESET_PC;
        prev_pc = TB_RESET_PC;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_cycle(vecs[i], i == 0, 8);

        // Reset landing in M1 abandons the cycle; the fetch restarts at RESET_PC.
        run_cycle(vecs[10], 1'b0, 3);
        pc_load   = 1'b0;
        x_drive   = 1'b1;
        x3_nibble = 4'hF;
        check_reset_state();
        sb.delete();
        rst     = 1'b0;
        x_drive = 1'b0;
        mpc     = TB_RESET_PC;
        prev_pc = TB_RESET_PC;
        @(negedge clk);
        run_cycle(vecs[0], 1'b1, 8);
        run_cycle(vecs[9], 1'b0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
